// File: rtl/inv_p_pkg.sv
// Shared definitions for the modular-inverse (P^-1 mod 2^W) engine.
package inv_p_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned DEF_W   = 65;
    localparam int unsigned DEF_BPC = 1;

    // Number of RUN cycles needed to resolve result bits 1..W-1.
    function automatic int unsigned run_cycles(input int unsigned w, input int unsigned bpc);
        return (w - 1 + bpc - 1) / bpc;
    endfunction

endpackage

// File: rtl/inv_p_step.sv
// One Hensel-lifting bit step: if bit idx of S is set, add P<<idx to clear it.
module inv_p_step #(
    parameter int unsigned W  = 8,
    parameter int unsigned IW = 4
) (
    input  logic [W-1:0]  i_s,
    input  logic [W-1:0]  i_p,
    input  logic [IW-1:0] i_idx,
    output logic          o_x,
    output logic [W-1:0]  o_s
);

    logic [W-1:0] w_bit;
    logic [W-1:0] w_add;

    // Bit select and shifted operand; shifts past W simply fall off.
    always_comb begin
        w_bit = W'(1) << i_idx;
        w_add = i_p << i_idx;
    end

    assign o_x = |(i_s & w_bit);
    assign o_s = o_x ? (i_s + w_add) : i_s;

endmodule

// File: rtl/inv_p_param.sv
// Iterative 2-adic inverse: X = P^-1 mod 2^W (or its negation), BPC bits per clock.
module inv_p_param
    import inv_p_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned BPC = DEF_BPC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in_p,
    input  logic         neg,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] out_inv
);

    localparam int unsigned IW     = $clog2(W + BPC) + 1;
    localparam int unsigned NCYC   = run_cycles(W, BPC);
    // Index held in r_i during the final RUN cycle.
    localparam int unsigned LAST_I = 1 + (NCYC - 1) * BPC;

    state_t        r_state;
    logic [W-1:0]  r_s;
    logic [W-1:0]  r_p;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_out;
    logic          r_neg;
    logic          r_err;
    logic [IW-1:0] r_i;

    logic [W-1:0]  w_s [BPC+1];
    logic [W-1:0]  w_x [BPC+1];
    logic          w_last;
    logic [W-1:0]  w_res;

    assign w_s[0] = r_s;
    assign w_x[0] = r_x;

    // Chain of BPC bit steps; steps beyond index W-1 pass S and X through.
    for (genvar k = 0; k < BPC; k++) begin : g_step
        logic [IW-1:0] w_idx;
        logic          w_vld;
        logic          w_bit;
        logic [W-1:0]  w_s_nxt;

        assign w_idx = r_i + IW'(k);
        assign w_vld = (w_idx <= IW'(W - 1));

        inv_p_step #(
            .W  (W),
            .IW (IW)
        ) u_step (
            .i_s   (w_s[k]),
            .i_p   (r_p),
            .i_idx (w_idx),
            .o_x   (w_bit),
            .o_s   (w_s_nxt)
        );

        assign w_s[k+1] = w_vld ? w_s_nxt : w_s[k];
        assign w_x[k+1] = (w_vld && w_bit) ? (w_x[k] | (W'(1) << w_idx)) : w_x[k];
    end

    assign w_last = (r_i == IW'(LAST_I));
    assign w_res  = r_neg ? (W'(0) - w_x[BPC]) : w_x[BPC];

    // Control and datapath state; result and err are loaded on entry to FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_p     <= '0;
            r_x     <= '0;
            r_out   <= '0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_i     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p   <= in_p;
                        r_neg <= neg;
                        r_s   <= in_p;
                        r_x   <= W'(1);
                        r_i   <= IW'(1);
                        if (in_p[0]) begin
                            r_state <= RUN;
                        end else begin
                            // Even P has no inverse: report straight away.
                            r_state <= FIN;
                            r_err   <= 1'b1;
                            r_out   <= '0;
                        end
                    end
                end
                RUN: begin
                    r_s <= w_s[BPC];
                    r_x <= w_x[BPC];
                    r_i <= r_i + IW'(BPC);
                    if (w_last) begin
                        r_state <= FIN;
                        r_out   <= w_res;
                        r_err   <= 1'b0;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == FIN);
    assign err     = r_err;
    assign out_inv = r_out;

endmodule

// File: doc/inv_p_param.md
INV_P_PARAM -- requirements
Module: inv_p_param

Interface
REQ-001 Parameter W, default 65: operand width in bits; legal range 2..1024.
REQ-002 Parameter BPC, default 1: result bits resolved per clock; legal values 1, 2, 4; W-1 need not be a multiple of BPC.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port start  input  1: one-cycle request; captures in_p and neg while idle.
REQ-006 Port in_p  input  W: modulus operand P.
REQ-007 Port neg  input  1: 0 selects X = P^-1 mod 2^W; 1 selects X = -P^-1 mod 2^W (Montgomery n').
REQ-008 Port busy  output  1: high while an inversion is in progress.
REQ-009 Port done  output  1: one-cycle pulse when out_inv and err are valid.
REQ-010 Port err  output  1: set with done when the captured P was even.
REQ-011 Port out_inv  output  W: result; holds its value until the next done.

Function
REQ-012 States: IDLE, RUN, FIN; reset enters IDLE.
REQ-013 IDLE with start=1: latch P and neg, set S=P, set X bit0=1 and other bits 0, set step index i=1, go to RUN, raise busy next cycle.
REQ-014 IDLE with start=1 and in_p[0]=0: skip RUN, go to FIN with err pending and result 0.
REQ-015 RUN per cycle, for each of up to BPC consecutive indices i (stop at i=W-1): x_i = S[i]; if x_i=1 then S = S + (P << i) mod 2^W; i = i+1. Each index uses the S updated by the previous index in the same cycle.
REQ-016 RUN to FIN when the last processed index equals W-1; RUN lasts exactly ceil((W-1)/BPC) cycles.
REQ-017 FIN, one cycle: out_inv = X when neg=0, or (2^W - X) mod 2^W when neg=1; err = P even; done=1; busy=0; next state IDLE.
REQ-018 Latency: done asserts ceil((W-1)/BPC)+1 cycles after the start cycle for odd P, and 1 cycle after for even P.
REQ-019 start while busy=1 or in FIN is ignored; the operation in flight is unaffected.
REQ-020 start may be asserted in the cycle after done; back-to-back throughput is one result per ceil((W-1)/BPC)+2 cycles.
REQ-021 Arithmetic: all sums are truncated to W bits; the shift P<<i discards bits at W and above.
REQ-022 Invariant at FIN for odd P: (P * X) mod 2^W = 1.
REQ-023 in_p and neg changes after the start cycle have no effect on the current result.

Reset
REQ-024 rst=1 forces, asynchronously: state=IDLE, busy=0, done=0, err=0, out_inv=0, S=0, X=0, i=0.
REQ-025 rst during RUN or FIN aborts the operation; no done is produced for it.
REQ-026 After rst deasserts, the first accepted start behaves as from power-up.

Structure
REQ-027 Shared package inv_p_pkg holds: state enum (IDLE/RUN/FIN), default W and BPC constants, and a function computing the cycle count ceil((W-1)/BPC).
REQ-028 One combinational sub-module, inv_p_step, performs a single bit-step. Inputs: S, P, i. Outputs: x_i, S'. It is instantiated BPC times in a chain.
REQ-029 Registers are limited to S, P, X, neg, i, state, out_inv and err. The block contains no multiplier.

Verification
REQ-030 W=8, BPC=1, P=3, neg=0 -> out_inv=171 (0xAB), err=0, done 8 cycles after start.
REQ-031 W=8, BPC=4, P=3, neg=1 -> out_inv=85 (0x55), done 3 cycles after start; P=1, neg=1 -> out_inv=255.
REQ-032 W=65, BPC=1, P=3, neg=0 -> out_inv=(2^65+1)/3 = 0x0AAAAAAAAAAAAAAAB, done 65 cycles after start; P=2^65-1 -> out_inv=2^65-1.
REQ-033 W=8, P=6 -> done 1 cycle after start, err=1, out_inv=0. A following start with P=5 -> out_inv=205, err=0.
REQ-034 Second start pulsed mid-RUN with a different P -> ignored; first result is correct. rst at RUN cycle 3 -> busy=0 and no done. Next start with P=7 (W=8) -> 183.
REQ-035 Random odd P for W in {8, 64, 65, 1024} and BPC in {1, 2, 4} -> (P*out_inv) mod 2^W equals 1 (neg=0) or 2^W-1 (neg=1).
